hysteresis_track: RTL

HYSTERESIS_TRACK -- requirements
Module: hysteresis_track

---
 rtl/edge_pkg.sv | 29 ++
 rtl/line_buffer2.sv | 37 +++
 rtl/hysteresis_track.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// edge_pkg
//   Shared definitions for the edge-detection pipeline: threshold class
//   encodings, final edge-map pixel values, the hysteresis tracker's FSM
//   state constants and a helper that folds the unused class code onto
//   "strong".
package edge_pkg;

  // Threshold classes carried in pixel bits [1:0]
  localparam logic [1:0] CLS_NONE   = 2'd0;
  localparam logic [1:0] CLS_WEAK   = 2'd1;
  localparam logic [1:0] CLS_STRONG = 2'd2;

  // Final edge-map pixel values
  localparam logic [7:0] EDGE_ON  = 8'd255;
  localparam logic [7:0] EDGE_OFF = 8'd0;

  // Hysteresis tracker FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Code 3 is not produced by the threshold stage on purpose; treat it as
  // strong so every 2-bit value has a defined meaning downstream.
  function automatic logic [1:0] norm_class(input logic [1:0] raw);
    return (raw == 2'd3) ? CLS_STRONG : raw;
  endfunction

endpackage

// File: rtl/line_buffer2.sv
// line_buffer2
//   One line of 2-bit class values, DEPTH entries deep, mapped onto block
//   RAM: one write port and one read port with a registered read.
//   Contents are deliberately not reset; the tracker masks rows that were
//   not yet written in the current frame.
//
// Ports
//   clk      : clock
//   wr_en    : write wr_data at wr_addr this cycle
//   wr_addr  : write column
//   wr_data  : class value to store
//   rd_addr  : read column (sampled every cycle)
//   rd_data  : contents of rd_addr as of the previous rising edge
module line_buffer2
  import edge_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hysteresis_track.sv
// hysteresis_track
//   Single-pass hysteresis edge tracking over a raster stream of threshold
//   classes. A 3x3 window slides over the frame; a centre pixel becomes an
//   edge if it is strong, or weak with at least one strong 8-neighbour.
//   Border pixels are always 0. Output for centre index j is produced one
//   cycle after pixel j+IMG_WIDTH+1 (its bottom-right neighbour) is
//   accepted; the tail of the frame is flushed with class-0 fill.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_pix/in_sof valid
//   in_ready  : input accepted this cycle when in_valid is high
//   in_sof    : accepted pixel is (0,0) of a new frame
//   in_pix    : class in bits [1:0]; bits [7:2] ignored
//   out_valid : out_pix carries one final pixel
//   out_pix   : 255 = edge, 0 = no edge; held while out_valid is low
module hysteresis_track
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sof,
  input  logic [7:0] in_pix,
  output logic       out_valid,
  output logic [7:0] out_pix
);

  localparam int CW = $clog2(IMG_WIDTH);
  // Rows count past the last line while flushing (virtual rows H and H+1)
  localparam int RW = $clog2(IMG_HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [1:0]    state_reg, state_next;
  logic [RW-1:0] row_reg, orow_reg, pos_row, adv_row;
  logic [CW-1:0] col_reg, ocol_reg, pos_col, adv_col, rd_col;
  logic          accept, sof_take, pix_take, flush_step, step, emit;
  logic [1:0]    lb1_rd, lb2_rd, new_top, new_mid, new_bot;
  logic [1:0]    win_reg  [9];
  logic [1:0]    win_next [9];
  logic [8:0]    strong_vec;
  logic          strong_nb, center_edge, out_border, last_out;
  logic [5:0]    unused_pix_bits;

  assign unused_pix_bits = in_pix[7:2];

  // Combinational on rst_n so the port reads 0 throughout reset
  assign in_ready = rst_n && (state_reg != ST_FLUSH);

  assign accept     = in_valid && in_ready;
  assign sof_take   = accept && in_sof;
  assign pix_take   = accept && !in_sof &&
                      ((state_reg == ST_FILL) || (state_reg == ST_RUN));
  assign flush_step = (state_reg == ST_FLUSH);
  // step: the window advances by one raster position (real or flush fill)
  assign step       = sof_take || pix_take || flush_step;
  assign emit       = (pix_take && (state_reg == ST_RUN)) || flush_step;

  // Raster position of the pixel entering the window this cycle, and the
  // position after it. The read address runs one column ahead so the
  // registered RAM read is already valid when the pixel arrives; during a
  // stall the address holds and the read data stays put.
  always_comb begin
    pos_row = sof_take ? '0 : row_reg;
    pos_col = sof_take ? '0 : col_reg;
    if (pos_col == COL_LAST) begin
      adv_col = '0;
      adv_row = pos_row + RW'(1);
    end else begin
      adv_col = pos_col + CW'(1);
      adv_row = pos_row;
    end
    rd_col = step ? adv_col : col_reg;
  end

  // New window column: two lines above, one line above, current pixel.
  // Line-buffer data is only trusted once that line was written this frame.
  assign new_top = (pos_row >= RW'(2)) ? lb2_rd : CLS_NONE;
  assign new_mid = (pos_row >= RW'(1)) ? lb1_rd : CLS_NONE;
  assign new_bot = flush_step ? CLS_NONE : norm_class(in_pix[1:0]);

  line_buffer2 #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .wr_en   (step),
    .wr_addr (pos_col),
    .wr_data (new_bot),
    .rd_addr (rd_col),
    .rd_data (lb1_rd)
  );

  line_buffer2 #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk     (clk),
    .wr_en   (step),
    .wr_addr (pos_col),
    .wr_data (new_mid),
    .rd_addr (rd_col),
    .rd_data (lb2_rd)
  );

  // Window is indexed col*3+row: column 0 oldest, row 0 top; centre is 4.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shift
      assign win_next[gi]     = win_reg[gi + 3];
      assign win_next[gi + 3] = win_reg[gi + 6];
    end
    for (gi = 0; gi < 9; gi++) begin : g_strong
      assign strong_vec[gi] = (win_next[gi] == CLS_STRONG);
    end
  endgenerate
  assign win_next[6] = new_top;
  assign win_next[7] = new_mid;
  assign win_next[8] = new_bot;

  // Decision uses the window after this step's shift. Window columns that
  // wrap across a line only ever surround border centres, which are forced
  // to 0, so no cross-line pixel influences a result.
  assign strong_nb   = |(strong_vec & 9'b111_101_111);
  assign center_edge = (win_next[4] == CLS_STRONG) ||
                       ((win_next[4] == CLS_WEAK) && strong_nb);
  assign out_border  = (orow_reg == '0) || (orow_reg == ROW_LAST) ||
                       (ocol_reg == '0) || (ocol_reg == COL_LAST);
  assign last_out    = (orow_reg == ROW_LAST) && (ocol_reg == COL_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sof_take) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (sof_take) begin
          state_next = ST_FILL;
        end else if (pix_take && (pos_row == RW'(1)) && (pos_col == '0)) begin
          // pixel IMG_WIDTH accepted: window now reaches the first centre
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sof_take) begin
          state_next = ST_FILL;
        end else if (pix_take && (pos_row == ROW_LAST) && (pos_col == COL_LAST)) begin
          state_next = ST_FLUSH;
        end
      end
      default: begin
        if (last_out) state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      orow_reg  <= '0;
      ocol_reg  <= '0;
      out_valid <= 1'b0;
      out_pix   <= EDGE_OFF;
      for (int i = 0; i < 9; i++) begin
        win_reg[i] <= CLS_NONE;
      end
    end else begin
      state_reg <= state_next;
      out_valid <= emit;
      if (emit) begin
        out_pix <= (!out_border && center_edge) ? EDGE_ON : EDGE_OFF;
      end
      if (step) begin
        win_reg <= win_next;
        row_reg <= adv_row;
        col_reg <= adv_col;
      end
      // Output position counter: restarts with every new frame
      if (sof_take) begin
        orow_reg <= '0;
        ocol_reg <= '0;
      end else if (emit) begin
        if (ocol_reg == COL_LAST) begin
          ocol_reg <= '0;
          orow_reg <= orow_reg + RW'(1);
        end else begin
          ocol_reg <= ocol_reg + CW'(1);
        end
      end
    end
  end

endmodule
